mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit placed beside the single-cycle ALU in the EX stage.
- Where the ALU answers combinationally, this block accepts an operation request and delivers its result some cycles later.
- Results land in architectural HI/LO registers. A busy flag tells the stall logic to hold any MDU-dependent instruction.
- Supports MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are always readable for MFHI/MFLO.

---
 rtl/mdu_iter.sv | 182 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit that sits beside the EX-stage ALU.
// Its results land in the architectural HI/LO registers.
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request strobe
//   op       in   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   a        in   rs operand (dividend / multiplicand / MT* data)
//   b        in   rt operand (divisor / multiplier)
//   busy     out  high while a MULT/DIV is in flight
//   hi, lo   out  HI/LO registers (registered; always readable)
//   state_o  out  FSM state for observation (0 IDLE, 1 MUL, 2 DIV)
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// A start seen while busy=1 is dropped with no side effect. The issuing
// pipeline must stall while busy=1, so busy works as an inverted ready. The
// completion edge still has busy=1, so a request held across that edge is
// taken on the following edge.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  // The divider datapath always does one restoring step per cycle over 32
  // bits, so this value must stay 32.
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   prod_q;
  logic [31:0]   rem_q;    // partial remainder
  logic [31:0]   dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [31:0]   dsr_q;    // divisor magnitude
  logic          q_neg_q;
  logic          r_neg_q;
  logic          dz_q;     // divide by zero
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  // Operand preparation for an accepted request.
  logic        is_signed_div;
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] a_abs, b_abs;

  always_comb begin
    is_signed_div = (op == OP_DIV);
    a_ext   = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext   = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    // The low 64 bits of the sign-extended product are the signed product.
    product = a_ext * b_ext;
    // -0x8000_0000 wraps back to 0x8000_0000, which is its correct unsigned
    // magnitude, so the overflow case needs no special handling.
    a_abs   = (is_signed_div && a[31]) ? (32'd0 - a) : a;
    b_abs   = (is_signed_div && b[31]) ? (32'd0 - b) : b;
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only if it does not go negative.
  logic [32:0] shifted, diff;
  logic [31:0] rem_d, dvd_d, quo_fin, rem_fin;

  always_comb begin
    shifted = {rem_q, dvd_q[31]};
    diff    = shifted - {1'b0, dsr_q};
    rem_d   = shifted[31:0];
    dvd_d   = {dvd_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      dvd_d = {dvd_q[30:0], 1'b1};
    end
    // On divide by zero every step succeeds, so the remainder ends up as
    // |a|. The sign fix then gives back a. The quotient is forced to all ones.
    quo_fin = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (32'd0 - dvd_d) : dvd_d);
    rem_fin = r_neg_q ? (32'd0 - rem_d) : rem_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                prod_q  <= product;
                cnt_q   <= CW'(MULT_CYCLES - 1);
                busy_q  <= 1'b1;
                state_q <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                rem_q   <= '0;
                dvd_q   <= a_abs;
                dsr_q   <= b_abs;
                q_neg_q <= is_signed_div & (a[31] ^ b[31]);
                r_neg_q <= is_signed_div & a[31];
                dz_q    <= (b == 32'd0);
                cnt_q   <= CW'(DIV_CYCLES - 1);
                busy_q  <= 1'b1;
                state_q <= S_DIV;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            hi_q    <= prod_q[63:32];
            lo_q    <= prod_q[31:0];
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          // The last step's result is committed on the same edge it completes.
          if (cnt_q == '0) begin
            hi_q    <= rem_fin;
            lo_q    <= quo_fin;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter. Directed vectors with hand-computed results. Each
// MULT/DIV issue pushes {completion_edge, hi, lo} into exp_q. A monitor pops
// and compares an entry whenever busy falls.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
  logic [1:0]  state_o;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [95:0] exp_q[$];
  logic        prev_busy = 1'b0;

  mdu_iter #(.MULT_CYCLES(5), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .state_o(state_o)
  );

  // clock / reset / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request at a negedge. Return the index of the edge that sampled it.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int unsigned k);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0; op = 3'd0;
  endtask

  task automatic push_exp(input int unsigned done_edge, input logic [31:0] h, input logic [31:0] l);
    exp_q.push_back({done_edge, h, l});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int unsigned lat, input logic [31:0] h, input logic [31:0] l);
    int unsigned k;
    issue(o, x, y, k);
    push_exp(k + lat, h, l);
    drain();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [95:0] e;
    if (!reset_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: hi=%h lo=%h at edge %0d", hi, lo, cyc);
        end else begin
          e = exp_q.pop_front();
          check32("done_edge", cyc, e[95:64]);
          check32("hi", hi, e[63:32]);
          check32("lo", lo, e[31:0]);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    int unsigned k;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // MTHI / MTLO write on the accepting edge. busy stays low.
    issue(3'd5, 32'h1234_5678, 32'd0, k);
    check32("mthi_hi", hi, 32'h1234_5678);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'hCAFE_BABE, 32'd0, k);
    check32("mtlo_lo", lo, 32'hCAFE_BABE);

    // NONE and reserved ops have no effect.
    issue(3'd0, 32'h1111_1111, 32'd1, k);
    issue(3'd7, 32'h2222_2222, 32'd2, k);
    @(negedge clk);
    check32("nop_hi", hi, 32'h1234_5678);
    check32("nop_lo", lo, 32'hCAFE_BABE);
    check32("nop_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a DIV clears everything at once.
    issue(3'd3, 32'd100, 32'd7, k);
    repeat (10) @(negedge clk);
    check32("div_mid_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check32("async_rst_hi", hi, 32'd0);
    check32("async_rst_lo", lo, 32'd0);
    check32("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    run(3'd4, 32'd100, 32'd7, 32, 32'd2, 32'd14);

    // The MULT busy window. An MTLO issued while busy is dropped.
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, k);
    push_exp(k + 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    check32("mult_busy", {31'd0, busy}, 32'd1);
    issue(3'd6, 32'h5555_5555, 32'd0, k);
    @(negedge clk);
    check32("mtlo_ignored_lo", lo, 32'd14);
    check32("mult_hold_hi", hi, 32'd2);
    drain();

    run(3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run(3'd3, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32, 32'h0000_0001, 32'h7FFF_FFFC);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h8000_0000);
    run(3'd4, 32'd5, 32'd0, 32, 32'd5, 32'hFFFF_FFFF);
    run(3'd3, 32'hFFFF_FFFB, 32'd0, 32, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run(3'd3, 32'd100, 32'hFFFF_FFF9, 32, 32'd2, 32'hFFFF_FFF2);

    // Back to back: start held high with a DIVU through the MULT completion.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd7; b = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    k = cyc;
    push_exp(k + 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    op = 3'd4; a = 32'd1000; b = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    check32("b2b_idle_gap", {31'd0, busy}, 32'd0);
    push_exp(k + 6 + 32, 32'd1, 32'd111);
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
    check32("b2b_div_busy", {31'd0, busy}, 32'd1);
    drain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
